// File: rtl/sequence_player_if.sv
// Command and status bundle between the simon_says controller and the sequence player.
// The controller side is the master; the player itself is the slave.
interface sequence_player_if;
    logic       start;
    logic       add_step;
    logic       ext_valid;
    logic [3:0] ext_sym;
    logic       clear;
    logic [3:0] rd_idx;
    logic [3:0] expected;
    logic [9:0] led;
    logic       busy;
    logic       play_done;
    logic [4:0] level;
    logic       full;

    modport master (
        output start, add_step, ext_valid, ext_sym, clear, rd_idx,
        input  expected, led, busy, play_done, level, full
    );

    modport slave (
        input  start, add_step, ext_valid, ext_sym, clear, rd_idx,
        output expected, led, busy, play_done, level, full
    );
endinterface

// File: rtl/sequence_player.sv
// Stores the growing simon_says pattern and plays it back one LED at a time,
// with a registered read port for the answer comparator.
module sequence_player #(
    parameter int         MAX_LEN    = 16,
    parameter int         ON_CYCLES  = 25_000_000,
    parameter int         OFF_CYCLES = 12_500_000,
    parameter logic [7:0] SEED       = 8'hA5
) (
    input  logic               clk,
    input  logic               reset,
    sequence_player_if.slave   bus
);
    localparam int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CW_ON   = $clog2(ON_CYCLES + 1);
    localparam int CW_OFF  = $clog2(OFF_CYCLES + 1);
    localparam int CW_T    = (CW_ON > CW_OFF) ? CW_ON : CW_OFF;
    localparam int CW      = (CW_T > 25) ? CW_T : 25;
    localparam logic [4:0]    MAX_LVL = 5'(MAX_LEN);
    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF, ST_DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            cnt_load;
    logic [AW-1:0]   idx;
    logic            idx_clr, idx_inc;
    logic [4:0]      level;
    logic [7:0]      lfsr;
    logic [3:0]      mem [MAX_LEN];
    logic [3:0]      rnd_sym, add_sym;
    logic            add_ok, last_sym;

    // Folding 10..15 down by ten keeps the random symbol inside 0..9.
    assign rnd_sym  = (lfsr[3:0] >= 4'd10) ? lfsr[3:0] - 4'd10 : lfsr[3:0];
    assign add_sym  = bus.ext_valid ? bus.ext_sym : rnd_sym;
    assign add_ok   = bus.add_step && !bus.clear && (state == ST_IDLE) &&
                      (level < MAX_LVL) && !(bus.ext_valid && (bus.ext_sym > 4'd9));
    assign last_sym = (5'(idx) == level - 5'd1);

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_nxt   = ON_LOAD;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        case (state)
            ST_IDLE: if (bus.start) begin
                // A same-cycle add_step counts towards the sequence being played.
                if (level != 5'd0 || add_ok) begin
                    state_nxt = ST_ON;
                    cnt_load  = 1'b1;
                    idx_clr   = 1'b1;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            ST_ON: if (cnt == '0) begin
                state_nxt = ST_OFF;
                cnt_load  = 1'b1;
                cnt_nxt   = OFF_LOAD;
            end
            ST_OFF: if (cnt == '0) begin
                if (last_sym) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_ON;
                    cnt_load  = 1'b1;
                    idx_inc   = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (bus.clear) state_nxt = ST_IDLE;

        bus.busy      = (state == ST_ON) || (state == ST_OFF);
        bus.play_done = (state == ST_DONE);
        bus.led       = (state == ST_ON) ? (10'd1 << mem[idx]) : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            idx          <= '0;
            level        <= '0;
            lfsr         <= SEED;
            bus.expected <= '0;
        end else begin
            state        <= state_nxt;
            lfsr         <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            bus.expected <= mem[bus.rd_idx[AW-1:0]];
            if (cnt_load)        cnt <= cnt_nxt;
            else if (cnt != '0)  cnt <= cnt - 1'b1;
            if (idx_clr)         idx <= '0;
            else if (idx_inc)    idx <= idx + 1'b1;
            if (bus.clear)       level <= '0;
            else if (add_ok)     level <= level + 5'd1;
        end
    end

    // NOTE: the symbol store has no reset; its contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (reset && add_ok) mem[level[AW-1:0]] <= add_sym;
    end

    assign bus.level = level;
    assign bus.full  = (level == MAX_LVL);
endmodule

// File: tb/tb_sequence_player.sv
// Directed bench for sequence_player: a timeline model of the playback checked every
// cycle, plus literal expectations for the hand-worked scenarios.
module tb_sequence_player;
    localparam int ON  = 3;
    localparam int OFF = 2;
    localparam int P   = ON + OFF;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    sequence_player_if bus();

    sequence_player #(.MAX_LEN(16), .ON_CYCLES(ON), .OFF_CYCLES(OFF), .SEED(8'hA5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Model: the stored pattern plus the time elapsed since playback began.
    logic [3:0] m_seq [16];
    bit         m_wr  [16];
    int         m_level   = 0;
    logic [7:0] m_lfsr;
    bit         m_playing = 0;
    int         m_t       = 0;
    int         m_len     = 0;
    logic [3:0] m_exp;
    bit         m_exp_ok  = 0;
    bit         m_init    = 0;

    initial foreach (m_wr[i]) m_wr[i] = 0;

    always @(posedge clk) begin
        bit idle;
        if (!reset) begin
            m_level   = 0;
            m_lfsr    = 8'hA5;
            m_playing = 0;
            m_exp     = '0;
            m_exp_ok  = 1;
            m_init    = 1;
        end else begin
            m_exp_ok = m_wr[bus.rd_idx];
            m_exp    = m_seq[bus.rd_idx];
            idle     = !m_playing;
            if (bus.clear) begin
                m_level   = 0;
                m_playing = 0;
            end else begin
                if (m_playing) begin
                    if (m_t == m_len * P + 1) m_playing = 0;
                    else m_t++;
                end
                if (idle && bus.add_step && m_level < 16 && !(bus.ext_valid && bus.ext_sym > 9)) begin
                    m_seq[m_level] = bus.ext_valid ? bus.ext_sym : 4'(m_lfsr[3:0] % 10);
                    m_wr[m_level]  = 1;
                    m_level++;
                end
                if (idle && bus.start) begin
                    m_playing = 1;
                    m_t       = 1;
                    m_len     = m_level;
                end
            end
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    always @(negedge clk) begin
        bit       busy_e, done_e;
        int       led_e;
        if (m_init) begin
            busy_e = m_playing && (m_t <= m_len * P);
            done_e = m_playing && (m_t == m_len * P + 1);
            led_e  = (busy_e && ((m_t - 1) % P < ON)) ? (1 << m_seq[(m_t - 1) / P]) : 0;
            check("led",       int'(bus.led),       led_e);
            check("busy",      int'(bus.busy),      int'(busy_e));
            check("play_done", int'(bus.play_done), int'(done_e));
            check("level",     int'(bus.level),     m_level);
            check("full",      int'(bus.full),      int'(m_level == 16));
            if (m_exp_ok) check("expected", int'(bus.expected), int'(m_exp));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while (!bus.play_done && n < max) begin
            step();
            n++;
        end
        check("wait_done", int'(bus.play_done), 1);
    endtask

    initial begin
        int syms [3] = '{2, 7, 0};
        int led_tab [16] = '{'h004, 'h004, 'h004, 0, 0, 'h080, 'h080, 'h080, 0, 0,
                             'h001, 'h001, 'h001, 0, 0, 0};
        int done_cnt;

        bus.start = 0; bus.add_step = 0; bus.ext_valid = 0; bus.ext_sym = '0;
        bus.clear = 0; bus.rd_idx = '0;
        reset = 0;
        step(2);
        check("lit_reset_led",      int'(bus.led), 0);
        check("lit_reset_busy",     int'(bus.busy), 0);
        check("lit_reset_level",    int'(bus.level), 0);
        check("lit_reset_full",     int'(bus.full), 0);
        check("lit_reset_expected", int'(bus.expected), 0);
        reset = 1;

        // Sequence 2, 7, 0 then a full playback.
        foreach (syms[i]) begin
            bus.add_step = 1; bus.ext_valid = 1; bus.ext_sym = 4'(syms[i]);
            step();
        end
        bus.add_step = 0; bus.ext_valid = 0;
        check("lit_level3", int'(bus.level), 3);
        bus.start = 1;
        step();
        bus.start = 0;
        for (int t = 1; t <= 16; t++) begin
            check("lit_play_led",  int'(bus.led), led_tab[t-1]);
            check("lit_play_done", int'(bus.play_done), int'(t == 16));
            step();
        end
        check("lit_idle_busy", int'(bus.busy), 0);

        bus.rd_idx = 4'd1;
        step();
        check("lit_expected_7", int'(bus.expected), 7);

        // add_step and start during playback are ignored.
        bus.start = 1;
        step();
        bus.start = 0;
        step();
        bus.add_step = 1; bus.ext_valid = 1; bus.ext_sym = 4'd5; bus.start = 1;
        step();
        bus.add_step = 0; bus.ext_valid = 0; bus.start = 0;
        check("lit_busy_add_ignored", int'(bus.level), 3);
        wait_done(40);
        step();

        // Clear during the second symbol's lit phase.
        bus.start = 1;
        step();
        bus.start = 0;
        step(5);
        check("lit_second_on", int'(bus.led), 'h080);
        bus.clear = 1;
        step();
        bus.clear = 0;
        check("lit_clear_led",   int'(bus.led), 0);
        check("lit_clear_busy",  int'(bus.busy), 0);
        check("lit_clear_level", int'(bus.level), 0);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.play_done) done_cnt++;
            step();
        end
        check("lit_clear_no_done", done_cnt, 0);

        // Out-of-range external symbol, then start with an empty sequence.
        bus.add_step = 1; bus.ext_valid = 1; bus.ext_sym = 4'd12;
        step();
        bus.add_step = 0; bus.ext_valid = 0;
        check("lit_ext12_level", int'(bus.level), 0);
        bus.start = 1;
        step();
        bus.start = 0;
        check("lit_empty_done", int'(bus.play_done), 1);
        check("lit_empty_led",  int'(bus.led), 0);
        step();
        check("lit_empty_done_once", int'(bus.play_done), 0);

        // Random fill to capacity, then one add_step too many.
        bus.add_step = 1; bus.ext_valid = 0;
        step(16);
        check("lit_fill_level", int'(bus.level), 16);
        check("lit_fill_full",  int'(bus.full), 1);
        step();
        bus.add_step = 0;
        check("lit_overfill_level", int'(bus.level), 16);
        for (int i = 0; i < 16; i++) begin
            bus.rd_idx = 4'(i);
            step();
            check("lit_rand_range", int'(bus.expected <= 4'd9), 1);
        end

        // Same-cycle add_step and start: the new symbol is played.
        bus.clear = 1;
        step();
        bus.clear = 0;
        bus.add_step = 1; bus.ext_valid = 1; bus.ext_sym = 4'd9; bus.start = 1;
        step();
        bus.add_step = 0; bus.ext_valid = 0; bus.start = 0;
        check("lit_addstart_led", int'(bus.led), 'h200);
        wait_done(20);
        step();

        // Reset in the middle of playback.
        bus.start = 1;
        step();
        bus.start = 0;
        step();
        reset = 0;
        step();
        check("lit_midreset_led",   int'(bus.led), 0);
        check("lit_midreset_busy",  int'(bus.busy), 0);
        check("lit_midreset_level", int'(bus.level), 0);
        reset = 1;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
